// File: rtl/md_unit_if.sv
// Interface bundling the E-stage multiply/divide request, HI/LO results
// and the D-stage stall handshake.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             E_Start;
  logic [2:0]       E_MDOp;
  logic [WIDTH-1:0] E_A;
  logic [WIDTH-1:0] E_B;
  logic             E_Cancel;
  logic             D_MDUse;
  logic             E_Busy;
  logic [WIDTH-1:0] E_HI;
  logic [WIDTH-1:0] E_LO;
  logic             E_Stall;

  // Pipeline side: issues md ops and consumes busy/stall/HI/LO.
  modport master (
    output E_Start, E_MDOp, E_A, E_B, E_Cancel, D_MDUse,
    input  E_Busy, E_HI, E_LO, E_Stall
  );

  // Multiply/divide unit side.
  modport slave (
    input  E_Start, E_MDOp, E_A, E_B, E_Cancel, D_MDUse,
    output E_Busy, E_HI, E_LO, E_Stall
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit: owns HI/LO, computes the result at issue,
// holds it as pending for a fixed busy window, then commits it.
// The interface WIDTH must match this module's WIDTH.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave mdIf
);

  typedef enum logic [0:0] {StIdle, StBusy} mdState_e;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  localparam logic [7:0] MultLoad = 8'(MULT_CYCLES);
  localparam logic [7:0] DivLoad  = 8'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] OneW = {{(WIDTH-1){1'b0}}, 1'b1};

  mdState_e         stateQ, stateD;
  logic [7:0]       cntQ, cntD;
  logic [WIDTH-1:0] hiQ, hiD;
  logic [WIDTH-1:0] loQ, loD;
  logic [WIDTH-1:0] pendHiQ, pendHiD;
  logic [WIDTH-1:0] pendLoQ, pendLoD;
  logic             pendWrQ, pendWrD;

  logic [2*WIDTH-1:0] prodSigned;
  logic [2*WIDTH-1:0] prodUnsigned;
  logic               divIsSigned;
  logic               aNeg, bNeg, divZero;
  logic [WIDTH-1:0]   divNum, divDen, denSafe;
  logic [WIDTH-1:0]   quotMag, remMag, quot, rem;
  logic [WIDTH-1:0]   resHi, resLo;
  logic               resWr;
  logic               isMdOp;

  // Multipliers: signed product via sign-extended operands, low 2*WIDTH bits are exact.
  always_comb begin
    prodSigned   = {{WIDTH{mdIf.E_A[WIDTH-1]}}, mdIf.E_A} * {{WIDTH{mdIf.E_B[WIDTH-1]}}, mdIf.E_B};
    prodUnsigned = {{WIDTH{1'b0}}, mdIf.E_A} * {{WIDTH{1'b0}}, mdIf.E_B};
  end

  // Shared unsigned divider; signed divide works on magnitudes and restores signs.
  // A zero divisor is swapped for 1 so the divider never sees it; the result is dropped.
  always_comb begin
    divIsSigned = (mdIf.E_MDOp == OpDiv);
    aNeg        = mdIf.E_A[WIDTH-1];
    bNeg        = mdIf.E_B[WIDTH-1];
    divZero     = (mdIf.E_B == '0);
    divNum      = (divIsSigned && aNeg) ? -mdIf.E_A : mdIf.E_A;
    divDen      = (divIsSigned && bNeg) ? -mdIf.E_B : mdIf.E_B;
    denSafe     = divZero ? OneW : divDen;
    quotMag     = divNum / denSafe;
    remMag      = divNum % denSafe;
    quot        = (divIsSigned && (aNeg ^ bNeg)) ? -quotMag : quotMag;
    rem         = (divIsSigned && aNeg) ? -remMag : remMag;
  end

  // Select the HI/LO result for the op being issued.
  always_comb begin
    resHi = '0;
    resLo = '0;
    resWr = 1'b1;
    case (mdIf.E_MDOp)
      OpMult:         {resHi, resLo} = prodSigned;
      OpMultu:        {resHi, resLo} = prodUnsigned;
      OpDiv, OpDivu: begin
        resHi = rem;
        resLo = quot;
        resWr = ~divZero;
      end
      default:        resWr = 1'b0;
    endcase
  end

  // Next-state: issue/move-to in IDLE, count down in BUSY; cancel wins over everything.
  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    hiD     = hiQ;
    loD     = loQ;
    pendHiD = pendHiQ;
    pendLoD = pendLoQ;
    pendWrD = pendWrQ;
    unique case (stateQ)
      StIdle: begin
        if (mdIf.E_Start && !mdIf.E_Cancel) begin
          case (mdIf.E_MDOp)
            OpMult, OpMultu, OpDiv, OpDivu: begin
              pendHiD = resHi;
              pendLoD = resLo;
              pendWrD = resWr;
              cntD    = mdIf.E_MDOp[1] ? DivLoad : MultLoad;
              stateD  = StBusy;
            end
            OpMthi:  hiD = mdIf.E_A;
            OpMtlo:  loD = mdIf.E_A;
            default: ;
          endcase
        end
      end
      StBusy: begin
        if (mdIf.E_Cancel) begin
          stateD  = StIdle;
          cntD    = '0;
          pendWrD = 1'b0;
        end else begin
          cntD = cntQ - 8'd1;
          if (cntQ == 8'd1) begin
            stateD  = StIdle;
            pendWrD = 1'b0;
            if (pendWrQ) begin
              hiD = pendHiQ;
              loD = pendLoQ;
            end
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // State, counter, HI/LO and pending result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ  <= StIdle;
      cntQ    <= '0;
      hiQ     <= '0;
      loQ     <= '0;
      pendHiQ <= '0;
      pendLoQ <= '0;
      pendWrQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      hiQ     <= hiD;
      loQ     <= loD;
      pendHiQ <= pendHiD;
      pendLoQ <= pendLoD;
      pendWrQ <= pendWrD;
    end
  end

  // Outputs; stall covers the issue cycle too so the D-stage op cannot slip past.
  always_comb begin
    isMdOp       = ~mdIf.E_MDOp[2];
    mdIf.E_Busy  = (stateQ == StBusy);
    mdIf.E_HI    = hiQ;
    mdIf.E_LO    = loQ;
    mdIf.E_Stall = mdIf.D_MDUse &
                   ((stateQ == StBusy) | (mdIf.E_Start & isMdOp & ~mdIf.E_Cancel));
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: a 32-bit default instance and a 16-bit, 1-cycle instance
// share random and directed stimulus and are checked each cycle against a
// reference model that computes results with plain integer arithmetic.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic        mdUse = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;

  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(32)) ifA ();
  md_unit_if #(.WIDTH(16)) ifB ();

  assign ifA.E_Start  = start;
  assign ifA.E_MDOp   = op;
  assign ifA.E_A      = opA;
  assign ifA.E_B      = opB;
  assign ifA.E_Cancel = cancel;
  assign ifA.D_MDUse  = mdUse;
  assign ifB.E_Start  = start;
  assign ifB.E_MDOp   = op;
  assign ifB.E_A      = opA[15:0];
  assign ifB.E_B      = opB[15:0];
  assign ifB.E_Cancel = cancel;
  assign ifB.D_MDUse  = mdUse;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dutA (
    .clk(clk), .reset(reset), .mdIf(ifA)
  );
  md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dutB (
    .clk(clk), .reset(reset), .mdIf(ifB)
  );

  logic        obsBusy  [2];
  logic        obsStall [2];
  logic [31:0] obsHi    [2];
  logic [31:0] obsLo    [2];
  assign obsBusy[0]  = ifA.E_Busy;
  assign obsBusy[1]  = ifB.E_Busy;
  assign obsStall[0] = ifA.E_Stall;
  assign obsStall[1] = ifB.E_Stall;
  assign obsHi[0]    = ifA.E_HI;
  assign obsHi[1]    = {16'h0, ifB.E_HI};
  assign obsLo[0]    = ifA.E_LO;
  assign obsLo[1]    = {16'h0, ifB.E_LO};

  int nCompared   = 0;
  int nMismatched = 0;
  string phase = "init";

  // Reference model state: cycles of busy left, architectural and pending HI/LO.
  int          mdlWidth   [2] = '{32, 16};
  int          mdlMultLat [2] = '{5, 1};
  int          mdlDivLat  [2] = '{10, 1};
  int          mdlRem     [2];
  logic [31:0] mdlHi      [2];
  logic [31:0] mdlLo      [2];
  logic [31:0] mdlPendHi  [2];
  logic [31:0] mdlPendLo  [2];
  bit          mdlPendWr  [2];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void refCalc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input int w, output logic [31:0] hi, output logic [31:0] lo,
                                  output bit wr);
    logic [63:0]     mask;
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    mask = (w == 32) ? 64'hFFFF_FFFF : 64'hFFFF;
    sa   = (w == 32) ? longint'($signed(a)) : longint'($signed(a[15:0]));
    sb   = (w == 32) ? longint'($signed(b)) : longint'($signed(b[15:0]));
    ua   = 64'(a) & mask;
    ub   = 64'(b) & mask;
    wr   = 1'b1;
    hi   = '0;
    lo   = '0;
    case (o)
      3'd0: begin
        p  = 64'(sa * sb);
        hi = 32'((p >> w) & mask);
        lo = 32'(p & mask);
      end
      3'd1: begin
        p  = 64'(ua * ub);
        hi = 32'((p >> w) & mask);
        lo = 32'(p & mask);
      end
      3'd2: begin
        if (sb == 0) wr = 1'b0;
        else begin
          lo = 32'(64'(sa / sb) & mask);
          hi = 32'(64'(sa % sb) & mask);
        end
      end
      3'd3: begin
        if (ub == 0) wr = 1'b0;
        else begin
          lo = 32'((ua / ub) & mask);
          hi = 32'((ua % ub) & mask);
        end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mdlRem[k]    = 0;
      mdlHi[k]     = '0;
      mdlLo[k]     = '0;
      mdlPendHi[k] = '0;
      mdlPendLo[k] = '0;
      mdlPendWr[k] = 1'b0;
    end
  endtask

  // Called at a falling edge with inputs already driven: compare, advance model, step clock.
  task automatic runCycle();
    #2;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] m;
      bit          expStall;
      expStall = mdUse && (mdlRem[k] > 0 || (start && op <= 3'd3 && !cancel));
      checkVal($sformatf("%s/busy%0d", phase, k), 32'(obsBusy[k]), 32'(mdlRem[k] > 0));
      checkVal($sformatf("%s/stall%0d", phase, k), 32'(obsStall[k]), 32'(expStall));
      checkVal($sformatf("%s/hi%0d", phase, k), obsHi[k], mdlHi[k]);
      checkVal($sformatf("%s/lo%0d", phase, k), obsLo[k], mdlLo[k]);
      m = (mdlWidth[k] == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      if (cancel) begin
        mdlRem[k]    = 0;
        mdlPendWr[k] = 1'b0;
      end else if (mdlRem[k] > 0) begin
        mdlRem[k]--;
        if (mdlRem[k] == 0 && mdlPendWr[k]) begin
          mdlHi[k] = mdlPendHi[k];
          mdlLo[k] = mdlPendLo[k];
        end
      end else if (start) begin
        if (op <= 3'd3) begin
          refCalc(op, opA, opB, mdlWidth[k], mdlPendHi[k], mdlPendLo[k], mdlPendWr[k]);
          mdlRem[k] = (op < 3'd2) ? mdlMultLat[k] : mdlDivLat[k];
        end else if (op == 3'd4) mdlHi[k] = opA & m;
        else if (op == 3'd5)     mdlLo[k] = opA & m;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one op for a cycle, then run n idle cycles counting busy cycles of the 32-bit unit.
  task automatic doOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic u, input int n, output int busyCnt);
    start = 1'b1; op = o; opA = a; opB = b; mdUse = u;
    runCycle();
    start = 1'b0;
    busyCnt = 0;
    repeat (n) begin
      if (obsBusy[0]) busyCnt++;
      runCycle();
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'hFFFF_8000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkVal("rst/hi", obsHi[0], 32'h0);
    checkVal("rst/lo", obsLo[0], 32'h0);
    checkVal("rst/busy", 32'(obsBusy[0]), 32'h0);
    checkVal("rst/stall", 32'(obsStall[0]), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    phase = "mult";
    doOp(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 8, bc);
    checkVal("mult/busy_len", 32'(bc), 32'd5);
    checkVal("mult/hi", obsHi[0], 32'hFFFF_FFFF);
    checkVal("mult/lo", obsLo[0], 32'hFFFF_FFFA);

    phase = "multu";
    doOp(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 7, bc);
    checkVal("multu/hi", obsHi[0], 32'h0000_0002);
    checkVal("multu/lo", obsLo[0], 32'hFFFF_FFFA);

    phase = "div";
    doOp(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 12, bc);
    checkVal("div/busy_len", 32'(bc), 32'd10);
    checkVal("div/hi", obsHi[0], 32'hFFFF_FFFF);
    checkVal("div/lo", obsLo[0], 32'hFFFF_FFFD);

    phase = "divu0";
    doOp(3'd3, 32'd7, 32'd0, 1'b0, 12, bc);
    checkVal("divu0/busy_len", 32'(bc), 32'd10);
    checkVal("divu0/hi", obsHi[0], 32'hFFFF_FFFF);
    checkVal("divu0/lo", obsLo[0], 32'hFFFF_FFFD);

    phase = "divovf";
    doOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 12, bc);
    checkVal("divovf/hi", obsHi[0], 32'h0);
    checkVal("divovf/lo", obsLo[0], 32'h8000_0000);

    phase = "mthi";
    doOp(3'd4, 32'h1234_5678, 32'd0, 1'b1, 1, bc);
    checkVal("mthi/busy_len", 32'(bc), 32'd0);
    checkVal("mthi/hi", obsHi[0], 32'h1234_5678);

    phase = "mtlo_cancel";
    cancel = 1'b1;
    doOp(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 0, bc);
    cancel = 1'b0;
    runCycle();
    checkVal("mtlo_cancel/lo", obsLo[0], 32'h8000_0000);

    phase = "div_cancel";
    doOp(3'd2, 32'd100, 32'd7, 1'b1, 3, bc);
    cancel = 1'b1;
    runCycle();
    cancel = 1'b0;
    checkVal("div_cancel/busy", 32'(obsBusy[0]), 32'h0);
    checkVal("div_cancel/hi", obsHi[0], 32'h1234_5678);
    checkVal("div_cancel/lo", obsLo[0], 32'h8000_0000);
    phase = "mult_after_cancel";
    doOp(3'd0, 32'd6, 32'd7, 1'b1, 7, bc);
    checkVal("mult_after_cancel/busy_len", 32'(bc), 32'd5);
    checkVal("mult_after_cancel/lo", obsLo[0], 32'd42);

    phase = "mid_reset";
    doOp(3'd3, 32'd1000, 32'd3, 1'b0, 4, bc);
    reset = 1'b0;
    #1;
    modelReset();
    checkVal("mid_reset/busy", 32'(obsBusy[0]), 32'h0);
    checkVal("mid_reset/hi", obsHi[0], 32'h0);
    checkVal("mid_reset/lo", obsLo[0], 32'h0);
    checkVal("mid_reset/stall", 32'(obsStall[0]), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    phase = "random";
    repeat (800) begin
      start  = ($urandom_range(0, 2) != 0);
      op     = 3'($urandom_range(0, 7));
      opA    = pickOperand();
      opB    = pickOperand();
      cancel = ($urandom_range(0, 15) == 0);
      mdUse  = 1'($urandom_range(0, 1));
      runCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage, next to the ALU. Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Owns the HI/LO registers.
- Asserts a busy window of parametrised length and generates the stall request that the D-stage hazard logic consumes.
- Generalises the fixed-latency datapath control to configurable width and latency, and adds cancel and stall behaviour.

Parameters:
WIDTH, 32, operand and HI/LO width in bits
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..255)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..255)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
E_Start  input  1  E-stage instruction is an md op; sampled every cycle
E_MDOp  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
E_A  input  WIDTH  rs operand (forwarded)
E_B  input  WIDTH  rt operand (forwarded)
E_Cancel  input  1  abort the in-flight op (flush)
D_MDUse  input  1  D-stage instruction reads/writes HI/LO or is an md op
E_Busy  output  1  multi-cycle op in progress
E_HI  output  WIDTH  HI register
E_LO  output  WIDTH  LO register
E_Stall  output  1  stall request to D stage

Behaviour:
Reset (reset=0, asynchronous):
- HI=0, LO=0, E_Busy=0, state=IDLE, counter=0, pending result=0.
- Reset asserted mid-operation discards the op immediately.

States: IDLE, BUSY. Counter width is 8 bits.

IDLE:
- E_Start=1 with MDOp 0-3: capture the result computed from E_A/E_B into pending HI/LO.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY.
  - E_Busy rises on the next edge.
- E_Start=1 with MDOp 4 (MTHI): HI<=E_A on the next edge. Stay IDLE, no busy.
- E_Start=1 with MDOp 5 (MTLO): LO<=E_A on the next edge. Stay IDLE, no busy.
- E_Start=1 with MDOp 6/7: no effect.

BUSY:
- Counter decrements every cycle.
- On the edge where the counter goes 1->0: HI/LO<=pending, E_Busy<=0, return to IDLE.
- Busy is therefore high for exactly N cycles.
- HI/LO keep their old values throughout BUSY.
- E_Start in BUSY is ignored. The hazard unit guarantees it cannot happen, because E_Stall holds the instruction in D.

E_Cancel=1:
- In BUSY: next state IDLE, E_Busy=0, HI/LO unchanged, pending discarded.
- In IDLE: suppresses any E_Start in the same cycle, including MTHI/MTLO.
- Cancel has priority over start and over completion in the same cycle.

Arithmetic:
- MULT: signed WIDTH x WIDTH -> 2*WIDTH. HI=upper half, LO=lower half.
- MULTU: same as MULT, unsigned.
- DIV: signed. LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
- DIVU: unsigned. LO=quotient, HI=remainder.
- Divide by zero: the op still occupies the busy window, but HI/LO are left unchanged at completion.
- DIV of most-negative / -1: LO=most-negative, HI=0.

E_Stall (combinational):
- E_Stall = D_MDUse & (E_Busy | (E_Start & MDOp<=3 & ~E_Cancel)).
- No stall for MTHI/MTLO alone; their result is visible to a following MFHI/MFLO, which reads in E one cycle later.

Test Plan:
1. Reset: drive reset=0 then release -> E_HI=0, E_LO=0, E_Busy=0, E_Stall=0, including after reset is asserted mid-BUSY.
2. MULT with A=0xFFFFFFFE (-2), B=3, WIDTH=32, MULT_CYCLES=5:
   - E_Busy high for exactly 5 cycles.
   - HI/LO hold their old values during busy.
   - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
   - MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
3. DIV with A=-7, B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIVU with A=7, B=0 -> 10 busy cycles, HI/LO unchanged.
   - DIV with 0x80000000 / -1 -> LO=0x80000000, HI=0.
4. MTHI A=0x12345678 -> HI updates at the next edge, E_Busy stays 0.
   - Cancel in the same cycle as an MTLO -> LO unchanged.
5. Start DIV, assert E_Cancel on busy cycle 4 -> E_Busy=0 on the next edge, HI/LO keep their pre-DIV values.
   - A new MULT can then start immediately and completes correctly.
6. Stall: D_MDUse=1 during the start cycle and all busy cycles -> E_Stall=1 in each of those cycles, and 0 in the completion+1 cycle.
   - D_MDUse=0 -> E_Stall=0 throughout.
   - Re-run with MULT_CYCLES=1, DIV_CYCLES=1 and WIDTH=16 to check parameter corners.
